// File: rtl/gauss_sched_pkg.sv
// Shared types and constants for the 5x5 Gaussian window sequencer.
package gauss_sched_pkg;

    localparam int unsigned KSIZE = 5;
    localparam int unsigned NTAPS = 25;

    // sigma_sel encoding
    localparam logic [1:0] Sigma3 = 2'd0;
    localparam logic [1:0] Sigma5 = 2'd1;
    localparam logic [1:0] Sigma7 = 2'd2;
    localparam logic [1:0] Sigma9 = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StScan,
        StDone
    } state_e;

endpackage

// File: rtl/gauss_win_addr.sv
// Window origin / tap counters and frame-store read address for the raster scan.
module gauss_win_addr
    import gauss_sched_pkg::*;
#(
    parameter int unsigned N  = 64,
    parameter int unsigned M  = 64,
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [AW-1:0] raddr,
    output logic [4:0]    tap,
    output logic          last_tap,
    output logic          last_win
);

    localparam int unsigned RW = $clog2(N);
    localparam int unsigned CW = $clog2(M);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [2:0]    r_q, r_d;
    logic [2:0]    c_q, c_d;
    logic          last_row, last_col;

    assign last_row = (row_q == RW'(N - KSIZE));
    assign last_col = (col_q == CW'(M - KSIZE));
    assign last_win = last_row & last_col;
    assign tap      = 5'(r_q) * 5'(KSIZE) + 5'(c_q);
    assign last_tap = (tap == 5'(NTAPS - 1));
    assign raddr    = (AW'(row_q) + AW'(r_q)) * AW'(M) + AW'(col_q) + AW'(c_q);

    // Origin advances on the tap-24 step; after the last window it wraps to 0 for the next frame.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        r_d   = r_q;
        c_d   = c_q;
        if (step) begin
            if (c_q != 3'(KSIZE - 1)) begin
                c_d = c_q + 3'd1;
            end else begin
                c_d = '0;
                if (r_q != 3'(KSIZE - 1)) begin
                    r_d = r_q + 3'd1;
                end else begin
                    r_d = '0;
                    if (!last_col) begin
                        col_d = col_q + CW'(1);
                    end else begin
                        col_d = '0;
                        row_d = last_row ? '0 : row_q + RW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            r_q   <= '0;
            c_q   <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            r_q   <= r_d;
            c_q   <= c_d;
        end
    end

endmodule

// File: rtl/gauss_window_sched.sv
// Frame sequencer: loads one frame into the frame store, then streams every 5x5 window
// as 25 tagged taps to the MAC datapath.
module gauss_window_sched
    import gauss_sched_pkg::*;
#(
    parameter int unsigned N  = 64,
    parameter int unsigned M  = 64,
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    Din,
    input  logic          data_valid,
    input  logic [1:0]    sigma_sel,
    input  logic          mac_busy,
    input  logic [7:0]    mem_rdata,
    output logic          fill_now,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [7:0]    mem_wdata,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    output logic          tap_valid,
    output logic [4:0]    tap_idx,
    output logic [7:0]    tap_data,
    output logic          win_last,
    output logic [1:0]    sigma_q,
    output logic          frame_done
);

    state_e        state_q, state_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [1:0]    sigma_d;
    logic          tap_valid_q, win_last_q;
    logic [4:0]    tap_idx_q;
    logic [4:0]    tap;
    logic          last_tap, last_win;

    gauss_win_addr #(
        .N  (N),
        .M  (M),
        .AW (AW)
    ) u_addr (
        .clk      (clk),
        .rst      (rst),
        .step     (mem_re),
        .raddr    (mem_raddr),
        .tap      (tap),
        .last_tap (last_tap),
        .last_win (last_win)
    );

    assign mem_we     = data_valid & fill_now;
    assign mem_wdata  = Din;
    assign mem_waddr  = waddr_q;
    assign tap_valid  = tap_valid_q;
    assign tap_idx    = tap_idx_q;
    assign win_last   = win_last_q;
    // Frame store output is already registered; gate it so tap_data reads 0 between taps.
    assign tap_data   = tap_valid_q ? mem_rdata : 8'd0;

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        sigma_d    = sigma_q;
        fill_now   = 1'b0;
        mem_re     = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                fill_now = 1'b1;
                if (data_valid) begin
                    sigma_d = sigma_sel;
                    waddr_d = AW'(1);
                    state_d = StLoad;
                end
            end
            StLoad: begin
                fill_now = 1'b1;
                if (data_valid) begin
                    if (waddr_q == AW'(N * M - 1)) begin
                        waddr_d = '0;
                        state_d = StWait;
                    end else begin
                        waddr_d = waddr_q + AW'(1);
                    end
                end
            end
            StWait: begin
                if (!mac_busy) state_d = StScan;
            end
            StScan: begin
                mem_re = 1'b1;
                if (last_tap) begin
                    if (last_win)      state_d = StDone;
                    else if (mac_busy) state_d = StWait;
                end
            end
            StDone: begin
                frame_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            waddr_q     <= '0;
            sigma_q     <= '0;
            tap_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            win_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            sigma_q     <= sigma_d;
            tap_valid_q <= mem_re;
            win_last_q  <= mem_re & last_tap;
            if (mem_re) tap_idx_q <= tap;
        end
    end

endmodule

// File: tb/tb_gauss_window_sched.sv
// Self-checking bench for gauss_window_sched on a small non-square frame.
module tb_gauss_window_sched;

    localparam int unsigned N        = 8;
    localparam int unsigned M        = 12;
    localparam int unsigned AW       = 7;
    localparam int unsigned NPIX     = N * M;
    localparam int unsigned NWIN     = (N - 4) * (M - 4);
    localparam int unsigned SCAN_CYC = NWIN * 25;

    typedef struct packed {
        logic [4:0] idx;
        logic [7:0] data;
        logic       last;
    } tap_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    Din = 8'd0;
    logic          data_valid = 1'b0;
    logic [1:0]    sigma_sel = 2'd0;
    logic          mac_busy = 1'b0;
    logic [7:0]    mem_rdata;
    logic          fill_now, mem_we, mem_re, tap_valid, win_last, frame_done;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [7:0]    mem_wdata, tap_data;
    logic [4:0]    tap_idx;
    logic [1:0]    sigma_q;

    logic [7:0]    fmem [2**AW];
    logic [7:0]    img [NPIX];
    tap_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [1:0]    exp_sigma;
    int            n_tests = 0;
    int            n_fail  = 0;

    gauss_window_sched #(
        .N  (N),
        .M  (M),
        .AW (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Din        (Din),
        .data_valid (data_valid),
        .sigma_sel  (sigma_sel),
        .mac_busy   (mac_busy),
        .mem_rdata  (mem_rdata),
        .fill_now   (fill_now),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_raddr  (mem_raddr),
        .tap_valid  (tap_valid),
        .tap_idx    (tap_idx),
        .tap_data   (tap_data),
        .win_last   (win_last),
        .sigma_q    (sigma_q),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // External frame store: registered read, one cycle latency.
    always @(posedge clk) begin
        if (mem_we) fmem[mem_waddr] <= mem_wdata;
        mem_rdata <= fmem[mem_raddr];
    end

    task automatic build_expect();
        tap_t t;
        int   a;
        exp_q.delete();
        addr_q.delete();
        for (int row = 0; row <= int'(N) - 5; row++)
            for (int col = 0; col <= int'(M) - 5; col++)
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++) begin
                        a = (row + r) * int'(M) + col + c;
                        addr_q.push_back(AW'(a));
                        t.idx  = 5'(r * 5 + c);
                        t.data = img[a];
                        t.last = (r == 4) && (c == 4);
                        exp_q.push_back(t);
                    end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({fill_now, mem_we, mem_re, tap_valid, win_last, frame_done, tap_idx, tap_data,
             mem_raddr, mem_waddr, sigma_q} !==
            {1'b1, 5'b0, 5'd0, 8'd0, AW'(0), AW'(0), 2'd0}) begin
            n_fail++;
            $display("FAIL reset_values: fill=%b we=%b re=%b tv=%b wl=%b fd=%b idx=%0d td=%0d ra=%0d wa=%0d sig=%0d, want fill=1 rest 0",
                     fill_now, mem_we, mem_re, tap_valid, win_last, frame_done, tap_idx,
                     tap_data, mem_raddr, mem_waddr, sigma_q);
        end
        @(posedge clk);
        #1;
    endtask

    // Streams one frame; returns at posedge+1 of the first cycle after the last write.
    task automatic load_frame(input logic [7:0] salt, input int gap_every,
                              input logic [1:0] s_first, input logic [1:0] s_mid);
        int a = 0;
        int cyc = 0;
        exp_sigma = s_first;
        while (a < int'(NPIX)) begin
            if (gap_every != 0 && (cyc % gap_every) == gap_every - 1) begin
                data_valid = 1'b0;
                Din = 8'hee;
            end else begin
                data_valid = 1'b1;
                Din = 8'(a) ^ salt;
            end
            sigma_sel = (a >= int'(NPIX) / 2) ? s_mid : s_first;
            @(negedge clk);
            n_tests++;
            if ({fill_now, mem_we, mem_waddr, mem_wdata} !== {1'b1, data_valid, AW'(a), Din}) begin
                n_fail++;
                $display("FAIL load_write a=%0d: fill=%b we=%b waddr=%0d wdata=%h, want 1 %b %0d %h",
                         a, fill_now, mem_we, mem_waddr, mem_wdata, data_valid, a, Din);
            end
            if (data_valid) begin
                img[a] = Din;
                a++;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;
    endtask

    // Scans the loaded frame from the WAIT cycle on; optional stall after window 0 or reset abort.
    task automatic run_scan(input bit stall, input int abort_rd);
        int            rd = 0;
        int            busy_left = 0;
        int            idle = 0;
        int            exp_done;
        bit            stalled = 1'b0;
        bit            done = 1'b0;
        tap_t          t;
        logic [AW-1:0] ea;
        exp_done = int'(SCAN_CYC) + 1 + (stall ? 10 : 0);
        build_expect();
        for (int cyc = 0; cyc < int'(SCAN_CYC) + 40; cyc++) begin
            if (stall && rd == 24 && !stalled) begin
                stalled = 1'b1;
                busy_left = 10;
            end
            mac_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            data_valid = 1'(cyc & 1);
            Din = 8'h5a;
            sigma_sel = 2'(cyc);
            if (abort_rd >= 0 && rd == abort_rd) begin
                rst = 1'b1;
                data_valid = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if ({fill_now, mem_we, sigma_q} !== {2'b00, exp_sigma}) begin
                n_fail++;
                $display("FAIL scan_hold cyc=%0d: fill=%b we=%b sigma=%0d, want 0 0 %0d",
                         cyc, fill_now, mem_we, sigma_q, exp_sigma);
            end
            if (mem_re) begin
                n_tests++;
                if (addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_read cyc=%0d: raddr=%0d, want no read", cyc, mem_raddr);
                end else begin
                    ea = addr_q.pop_front();
                    if (mem_raddr !== ea) begin
                        n_fail++;
                        $display("FAIL raddr read=%0d: got %0d, want %0d", rd, mem_raddr, ea);
                    end
                end
                if (rd == 25) begin
                    n_tests++;
                    if (mem_raddr !== AW'(1)) begin
                        n_fail++;
                        $display("FAIL win1_start: raddr=%0d, want 1", mem_raddr);
                    end
                end
                if (rd == int'(M - 4) * 25) begin
                    n_tests++;
                    if (mem_raddr !== AW'(M)) begin
                        n_fail++;
                        $display("FAIL row_wrap: raddr=%0d, want %0d", mem_raddr, M);
                    end
                end
                rd++;
            end else if (rd > 0 && rd < int'(SCAN_CYC)) begin
                idle++;
            end
            if (tap_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_tap cyc=%0d: idx=%0d, want none", cyc, tap_idx);
                end else begin
                    t = exp_q.pop_front();
                    if ({tap_idx, tap_data, win_last} !== {t.idx, t.data, t.last}) begin
                        n_fail++;
                        $display("FAIL tap cyc=%0d: idx=%0d data=%h last=%b, want %0d %h %b",
                                 cyc, tap_idx, tap_data, win_last, t.idx, t.data, t.last);
                    end
                end
            end
            if (frame_done) begin
                n_tests++;
                if (abort_rd >= 0 || cyc != exp_done || tap_valid !== 1'b1 || exp_q.size() != 0 ||
                    addr_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL frame_done: cyc=%0d tv=%b taps_left=%0d reads_left=%0d, want cyc=%0d tv=1 0 0 no abort",
                             cyc, tap_valid, exp_q.size(), addr_q.size(), exp_done);
                end
                done = 1'b1;
                break;
            end
            if (rst) begin
                @(posedge clk);
                #1 rst = 1'b0;
                mac_busy = 1'b0;
                @(negedge clk);
                n_tests++;
                if ({fill_now, mem_we, mem_re, tap_valid, win_last, frame_done, tap_idx, tap_data,
                     mem_raddr, mem_waddr, sigma_q} !==
                    {1'b1, 5'b0, 5'd0, 8'd0, AW'(0), AW'(0), 2'd0}) begin
                    n_fail++;
                    $display("FAIL abort_reset: fill=%b we=%b re=%b tv=%b wl=%b fd=%b idx=%0d td=%0d ra=%0d wa=%0d sig=%0d, want fill=1 rest 0",
                             fill_now, mem_we, mem_re, tap_valid, win_last, frame_done, tap_idx,
                             tap_data, mem_raddr, mem_waddr, sigma_q);
                end
                @(posedge clk);
                #1;
                @(negedge clk);
                n_tests++;
                if ({fill_now, frame_done, mem_re} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL abort_idle: fill=%b fd=%b re=%b, want 1 0 0",
                             fill_now, frame_done, mem_re);
                end
                @(posedge clk);
                #1;
                exp_q.delete();
                addr_q.delete();
                return;
            end
            @(posedge clk);
            #1;
        end
        mac_busy = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: reads=%0d, want frame_done at cyc %0d", rd, exp_done);
            return;
        end
        n_tests++;
        if (idle != (stall ? 10 : 0)) begin
            n_fail++;
            $display("FAIL read_gaps: idle=%0d, want %0d", idle, stall ? 10 : 0);
        end
        @(posedge clk);
        #1 data_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({fill_now, frame_done, mem_re} !== 3'b100) begin
            n_fail++;
            $display("FAIL post_done_idle: fill=%b fd=%b re=%b, want 1 0 0",
                     fill_now, frame_done, mem_re);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_frame();
        load_frame(8'h00, 0, 2'd2, 2'd1);
        run_scan(1'b0, -1);
    endtask

    task automatic test_reset_mid_scan();
        load_frame(8'h3c, 0, 2'd1, 2'd3);
        run_scan(1'b0, 60);
    endtask

    task automatic test_back_to_back_stall();
        load_frame(8'hc5, 3, 2'd3, 2'd0);
        run_scan(1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_reset_mid_scan();
        test_back_to_back_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gauss_window_sched.md
# gauss_window_sched

Frame-level sequencer for the 5x5 Gaussian convolution datapath. It writes one incoming N x M pixel frame into an external single-port-read / single-port-write frame store. It then scans every valid 5x5 window position in raster order, issuing 25 tap reads per window and streaming the returned pixels, tagged with tap index, to the MAC datapath. It also latches the sigma selection per frame, honours datapath back-pressure at window boundaries, and signals frame completion.

## Interface
Parameters:
- N, 64, image rows
- M, 64, image columns
- AW, 12, frame-store address width; must satisfy 2^AW >= N*M

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- Din  in  8  pixel byte
- data_valid  in  1  Din valid this cycle
- sigma_sel  in  2  kernel select (0..3 = sigma 3/5/7/9)
- mac_busy  in  1  datapath cannot start a new window
- mem_rdata  in  8  frame-store read data, 1-cycle latency
- fill_now  out  1  block accepts pixels (IDLE or LOAD)
- mem_we  out  1  frame-store write strobe
- mem_waddr  out  AW  write address
- mem_wdata  out  8  write data
- mem_re  out  1  read strobe
- mem_raddr  out  AW  read address
- tap_valid  out  1  tap_data valid
- tap_idx  out  5  tap index 0..24 (5*r + c)
- tap_data  out  8  pixel for the tap
- win_last  out  1  high with tap_idx 24
- sigma_q  out  2  sigma latched for the current frame
- frame_done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, WAIT, SCAN, DONE.
- IDLE: fill_now=1.
  - On data_valid: write Din at address 0, latch sigma_sel into sigma_q, set waddr=1, go to LOAD.
- LOAD: fill_now=1.
  - Each data_valid writes Din at waddr and increments waddr. Gaps in data_valid are allowed.
  - The write at address N*M-1 moves the block to WAIT.
- WAIT: no reads issued. Goes to SCAN on the first cycle mac_busy=0.
- SCAN: one read per cycle.
  - mem_raddr = (row+r)*M + (col+c), with c as the inner counter 0..4 and r 0..4.
  - Window origin: row 0..N-5, col 0..M-5; col is the inner counter.
  - On issuing tap 24:
    - Last window (row=N-5, col=M-5): go to DONE.
    - Otherwise, if mac_busy=0: advance the origin and continue SCAN with tap 0 on the next cycle.
    - Otherwise: advance the origin and go to WAIT.
- DONE: assert frame_done for one cycle, then go to IDLE.
- With fill_now=0, data_valid is ignored and no writes occur.
- sigma_sel changes mid-frame have no effect until the next IDLE capture.
- mem_we = data_valid & fill_now. mem_wdata = Din, combinational.
- Address arithmetic is unsigned at AW bits. No wrap is possible for legal N, M.

## Timing
- Reset (sync, active-high) sets:
  - state IDLE, all counters 0
  - mem_we, mem_re, tap_valid, win_last, frame_done = 0
  - tap_idx, tap_data, mem_raddr, mem_waddr, sigma_q = 0
  - fill_now = 1 in the cycle after reset.
- Reset mid-frame aborts immediately. Frame-store contents are left as-is but discarded. No frame_done is issued.
- Tap latency: read issued in cycle t produces tap_valid, tap_idx and tap_data (registered from mem_rdata) in cycle t+1.
- tap_idx and win_last are pipelined one cycle to match the data.
- With mac_busy=0 throughout, windows are back-to-back at 25 cycles each.
  - A full 64x64 frame takes 60*60*25 = 90000 SCAN cycles.
  - The final tap_valid coincides with frame_done.
- mac_busy is sampled only in WAIT and on the tap-24 issue cycle. It never stalls a window in progress.
- Load-to-scan: WAIT is entered the cycle after the last write. The first read is issued at earliest one cycle after that.

## Structure
- Package gauss_sched_pkg holds:
  - state enum
  - KSIZE=5, NTAPS=25
  - sigma encoding constants
- Sub-module gauss_win_addr: row, col, r and c counters; raddr computation; last-tap and last-window flags.
- The top-level holds the FSM, write path and tap pipeline register.

## Test plan
- Reset, then stream 4096 pixels with Din=addr[7:0] and data_valid continuous -> 4096 writes to addresses 0..4095, fill_now drops after the last write, then WAIT.
- mac_busy=0 -> first window taps 0..24 carry Din values {0,1,2,3,4,64,65,..,260}[7:0], win_last on tap 24, frame_done exactly 90001 cycles after WAIT is entered (1 WAIT cycle + 90000 SCAN cycles).
- Hold mac_busy=1 for 10 cycles at the end of window 0 -> no mem_re for those cycles, window 1 begins at origin (0,1) with first address 1.
- Window at col=M-5 -> next origin is (row+1, 0). Origin (0,59) is followed by origin (1,0), first read address 64.
- sigma_sel=2 at first pixel, changed to 1 mid-load -> sigma_q=2 for the whole frame.
- Assert rst during SCAN -> next cycle all outputs are at reset values, no frame_done, and a new frame loads correctly.
